// File: rtl/add_sub_serial_p.sv
// Digit-serial adder/subtractor with masked operand capture.
// Processes DIGIT bits per cycle, LSB digit first, after an optional setup delay.
module add_sub_serial_p #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1,
   parameter int unsigned PRE_CYCLES = 1,
   parameter logic [WIDTH-1:0] A_MASK = '0,
   parameter logic [WIDTH-1:0] B_MASK = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = $clog2(N + 16);
   localparam logic [CW-1:0] N_LAST = CW'(N - 1);
   localparam logic [CW-1:0] PRE_LAST =
      CW'((PRE_CYCLES == 0) ? 0 : PRE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ADD,
      S_DONE
   } state_t;

   state_t state, state_nx;
   logic [CW-1:0] count, count_nx;
   logic accept;

   logic [WIDTH-1:0] a_reg, b_reg;
   logic carry;
   logic [DIGIT:0] s;
   logic msb_cin;
   logic [WIDTH-1:0] out_nx;

   // state and step counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         count <= '0;
      end else begin
         state <= state_nx;
         count <= count_nx;
      end
   end

   // next-state, counter and accept decode
   always_comb begin
      state_nx = state;
      count_nx = count;
      accept   = 1'b0;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               accept   = 1'b1;
               count_nx = '0;
               state_nx = (PRE_CYCLES == 0) ? S_ADD : S_SETUP;
            end
         end
         S_SETUP: begin
            if (count == PRE_LAST) begin
               state_nx = S_ADD;
               count_nx = '0;
            end else begin
               count_nx = count + 1'b1;
            end
         end
         S_ADD: begin
            if (count == N_LAST) begin
               state_nx = S_DONE;
               count_nx = '0;
            end else begin
               count_nx = count + 1'b1;
            end
         end
         default: begin
            state_nx = S_IDLE;
            count_nx = '0;
         end
      endcase
   end

   // one digit of the sum; the top sum bit recovers the carry into the MSB
   always_comb begin
      s = {1'b0, a_reg[DIGIT-1:0]}
        + {1'b0, b_reg[DIGIT-1:0]}
        + {{DIGIT{1'b0}}, carry};
      msb_cin = s[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
      out_nx = (out >> DIGIT)
             | (WIDTH'(s[DIGIT-1:0]) << (WIDTH - DIGIT));
   end

   // operand capture and serial datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         out   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         a_reg <= a ^ A_MASK;
         b_reg <= (b ^ B_MASK) ^ {WIDTH{sub}};
         carry <= cin ^ sub;
         out   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == S_ADD) begin
         a_reg <= a_reg >> DIGIT;
         b_reg <= b_reg >> DIGIT;
         carry <= s[DIGIT];
         out   <= out_nx;
         if (count == N_LAST) begin
            cout <= s[DIGIT];
            ovf  <= msb_cin ^ s[DIGIT];
         end
      end
   end

   assign busy = (state == S_SETUP) || (state == S_ADD);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_add_sub_serial_p.sv
// Bench for add_sub_serial_p: three parameterisations checked
// against an integer-arithmetic reference model.
module tb_add_sub_serial_p;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        start  [3];
   logic [15:0] a_in   [3];
   logic [15:0] b_in   [3];
   logic        sub_in [3];
   logic        cin_in [3];
   logic        co     [3];
   logic        ov     [3];
   logic        bz     [3];
   logic        dn     [3];
   logic [7:0]  o0;
   logic [15:0] o1;
   logic [7:0]  o2;

   int          wid     [3] = '{8, 16, 8};
   int          lat_exp [3] = '{9, 4, 7};
   logic [15:0] amask   [3] = '{16'h0, 16'h0, 16'h00E8};
   logic [15:0] bmask   [3] = '{16'h0, 16'h0, 16'h0096};

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   add_sub_serial_p u0 (
      .clk(clk), .rst(rst), .start(start[0]),
      .a(a_in[0][7:0]), .b(b_in[0][7:0]),
      .sub(sub_in[0]), .cin(cin_in[0]),
      .out(o0), .cout(co[0]), .ovf(ov[0]),
      .busy(bz[0]), .done(dn[0])
   );

   add_sub_serial_p #(
      .WIDTH(16), .DIGIT(4), .PRE_CYCLES(0)
   ) u1 (
      .clk(clk), .rst(rst), .start(start[1]),
      .a(a_in[1]), .b(b_in[1]),
      .sub(sub_in[1]), .cin(cin_in[1]),
      .out(o1), .cout(co[1]), .ovf(ov[1]),
      .busy(bz[1]), .done(dn[1])
   );

   add_sub_serial_p #(
      .WIDTH(8), .DIGIT(2), .PRE_CYCLES(3),
      .A_MASK(8'hE8), .B_MASK(8'h96)
   ) u2 (
      .clk(clk), .rst(rst), .start(start[2]),
      .a(a_in[2][7:0]), .b(b_in[2][7:0]),
      .sub(sub_in[2]), .cin(cin_in[2]),
      .out(o2), .cout(co[2]), .ovf(ov[2]),
      .busy(bz[2]), .done(dn[2])
   );

   function automatic logic [15:0] obs_out(input int i);
      case (i)
         0: return {8'h00, o0};
         1: return o1;
         default: return {8'h00, o2};
      endcase
   endfunction

   // Reference: exact integer arithmetic, then reduce modulo 2^w.
   function automatic void model(
      input int w, input logic [15:0] av, bv,
      input logic s, c,
      output logic [15:0] r, output logic co_e, ov_e
   );
      longint m, x, y, t, sx, sy, st;
      m = longint'(1) << w;
      x = longint'(av);
      y = longint'(bv);
      if (s) t = x - y - longint'(c);
      else   t = x + y + longint'(c);
      co_e = s ? (t >= 0) : (t >= m);
      r = 16'(t & (m - 1));
      sx = (x >= m / 2) ? x - m : x;
      sy = (y >= m / 2) ? y - m : y;
      if (s) st = sx - sy - longint'(c);
      else   st = sx + sy + longint'(c);
      ov_e = (st >= m / 2) || (st < -(m / 2));
   endfunction

   task automatic run_op(
      input int i, input logic [15:0] av, bv,
      input logic s, c, input bit pulse, input string tag,
      output logic [15:0] er
   );
      logic eco, eov;
      logic [15:0] wm;
      int lat;
      wm = 16'((longint'(1) << wid[i]) - 1);
      model(wid[i], (av ^ amask[i]) & wm, (bv ^ bmask[i]) & wm,
            s, c, er, eco, eov);
      @(negedge clk);
      start[i] = 1'b1;
      a_in[i] = av; b_in[i] = bv;
      sub_in[i] = s; cin_in[i] = c;
      @(posedge clk); #1;
      start[i] = 1'b0;
      a_in[i] = 16'($urandom); b_in[i] = 16'($urandom);
      sub_in[i] = ~s; cin_in[i] = ~c;
      n_checks++;
      if (bz[i] !== 1'b1 || dn[i] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s accept: busy=%b done=%b want busy=1 done=0",
                  tag, bz[i], dn[i]);
      end
      lat = 0;
      while (dn[i] !== 1'b1 && lat < 200) begin
         if (pulse && lat == lat_exp[i] - 2) start[i] = 1'b1;
         else start[i] = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      start[i] = 1'b0;
      n_checks++;
      if (lat != lat_exp[i]) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d",
                  tag, lat, lat_exp[i]);
      end
      n_checks++;
      if (obs_out(i) !== er || co[i] !== eco || ov[i] !== eov) begin
         n_fail++;
         $display("FAIL %s result: out=%h cout=%b ovf=%b want %h %b %b",
                  tag, obs_out(i), co[i], ov[i], er, eco, eov);
      end
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0; a_in[i] = '0; b_in[i] = '0;
         sub_in[i] = 1'b0; cin_in[i] = 1'b0;
      end
      #12;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (obs_out(i) !== 16'h0 || co[i] !== 1'b0 || ov[i] !== 1'b0 ||
             bz[i] !== 1'b0 || dn[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset%0d: out=%h c=%b v=%b busy=%b done=%b want 0",
                     i, obs_out(i), co[i], ov[i], bz[i], dn[i]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed;
      logic [15:0] r;
      run_op(0, 16'h3C, 16'h0F, 1'b0, 1'b0, 1'b0, "add_3c_0f", r);
      run_op(0, 16'h7F, 16'h01, 1'b0, 1'b0, 1'b0, "add_ovf", r);
      run_op(0, 16'hFF, 16'h01, 1'b0, 1'b1, 1'b0, "add_cin", r);
      run_op(0, 16'h10, 16'h20, 1'b1, 1'b0, 1'b0, "sub_borrow", r);
      run_op(0, 16'h80, 16'h01, 1'b1, 1'b0, 1'b0, "sub_ovf", r);
      run_op(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, "w16_add", r);
      run_op(2, 16'h00ED, 16'h0095, 1'b0, 1'b0, 1'b0, "masked_add", r);
   endtask

   task automatic test_busy_ignore;
      logic [15:0] r;
      run_op(2, 16'h00ED, 16'h0095, 1'b0, 1'b0, 1'b1, "mask_pulse", r);
      run_op(0, 16'h5A, 16'h33, 1'b1, 1'b1, 1'b1, "d0_pulse", r);
   endtask

   task automatic test_hold;
      logic [15:0] r;
      run_op(0, 16'hA5, 16'h6E, 1'b0, 1'b1, 1'b0, "hold_op", r);
      repeat (3) begin
         a_in[0] = 16'($urandom); b_in[0] = 16'($urandom);
         @(posedge clk); #1;
         n_checks++;
         if (dn[0] !== 1'b1 || obs_out(0) !== r) begin
            n_fail++;
            $display("FAIL hold: done=%b out=%h want 1 %h",
                     dn[0], obs_out(0), r);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] r;
      @(negedge clk);
      start[0] = 1'b1; a_in[0] = 16'h3C; b_in[0] = 16'h0F;
      sub_in[0] = 1'b0; cin_in[0] = 1'b0;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (bz[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_rst busy: got %b want 1", bz[0]);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (obs_out(0) !== 16'h0 || bz[0] !== 1'b0 || dn[0] !== 1'b0 ||
          co[0] !== 1'b0 || ov[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst: out=%h busy=%b done=%b want 0 0 0",
                  obs_out(0), bz[0], dn[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(0, 16'h91, 16'h2C, 1'b0, 1'b0, 1'b0, "after_rst", r);
      run_op(0, 16'h44, 16'hC8, 1'b1, 1'b1, 1'b0, "from_done", r);
   endtask

   task automatic test_back_to_back;
      logic [15:0] r;
      for (int k = 0; k < 3; k++)
         run_op(1, 16'($urandom), 16'($urandom), 1'($urandom),
                1'($urandom), 1'b0, "b2b_w16", r);
   endtask

   task automatic test_random;
      logic [15:0] r;
      for (int k = 0; k < 12; k++)
         for (int i = 0; i < 3; i++)
            run_op(i, 16'($urandom), 16'($urandom), 1'($urandom),
                   1'($urandom), 1'b0, "random", r);
   endtask

   initial begin
      test_reset;
      test_directed;
      test_busy_ignore;
      test_hold;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
